data_writer: RTL and testbench
==============================

// Module: data_writer
// PURPOSE
//  AXIS-to-memory deserializer; the write-side counterpart of the NM-memory serializing reader.
//  Packs NM consecutive B-bit samples from s_axis into one NM*B-bit word and writes the full 2**N-deep map once per START_REG run.
//  Sits between the capture stream and the NM parallel buffer memories.
// PARAMETERS
//  NM  8  number of memories / lanes per word; power of 2, >=2
//  N   8  memory address width; capture depth 2**N words
//  B   8  sample / lane data width
// PORTS
//  aclk            in   1     clock
//  aresetn         in   1     async active-low reset
//  s_axis_tvalid   in   1     sample valid
//  s_axis_tready   out  1     sample ready
//  s_axis_tdata    in   B     sample
//  s_axis_tlast    in   1     frame end; used only with the optional feature
//  mem_we          out  1     write strobe, common to all NM memories
//  mem_addr        out  N     write address
//  mem_di          out  NM*B  write data; lane k = bits [k*B +: B]
//  START_REG       in   1     run request, async; resynced internally
//  DONE_REG        out  1     high while run complete (END_ST)
//  ERR_REG         out  1     sticky frame error; constant 0 without the feature
// BEHAVIOUR
//  Reset (async, aresetn=0): state INIT_ST; all outputs 0; counters and data register 0.
//  States: INIT_ST -> RECV_ST when START_REG_resync=1; counters cleared, ERR_REG cleared on that transition.
//   RECV_ST: s_axis_tready=1. Accept on tvalid&tready; lane cnt_nm <= tdata; cnt_nm++.
//    Accept with cnt_nm==NM-1 -> WRITE_ST.
//   WRITE_ST: tready=0, mem_we=1 for exactly one cycle, mem_addr=cnt_addr, mem_di=packed word.
//    Next: cnt_addr++ and cnt_nm=0. If cnt_addr==2**N-1 -> END_ST, else -> RECV_ST.
//   END_ST: DONE_REG=1, tready=0. -> INIT_ST when START_REG_resync=0.
//  Packing: first accepted sample of a word -> lane 0 (LSBs); last -> lane NM-1.
//  Latency: last-sample handshake to mem_we = 1 cycle. One tready bubble per word; throughput NM/(NM+1).
//  mem_we is low outside WRITE_ST. mem_addr/mem_di hold their values between writes.
//  Address wrap: never wraps within a run. Exactly NM*2**N samples are accepted per run.
//  START_REG drop mid-run is ignored; the run completes. Re-run requires START low then high.
//  aresetn mid-run: the partial word is discarded; no write is issued.
//  START_REG passes through a synchronizer; it is high for >=3 aclk cycles before being sampled.
// CONFIGURATION
//  Macro DATA_WRITER_TLAST_CHECK_EN:
//   Defined: tlast on any sample except the final (cnt_addr=2**N-1, cnt_nm=NM-1) sets ERR_REG.
//    The partial word is written in WRITE_ST with unfilled lanes=0, then -> END_ST.
//    Final sample without tlast also sets ERR_REG; the run still ends normally.
//   Undefined: s_axis_tlast is ignored; ERR_REG tied 0.
// STRUCTURE
//  data_writer_pkg: state_t enum {INIT_ST, RECV_ST, WRITE_ST, END_ST}.
//  Sub-module: synchronizer_n instance for START_REG -> START_REG_resync.
//  Counters cnt_addr[N], cnt_nm[$clog2(NM)], and data register NM*B live in the top.
// TESTING (NM=4, N=2, B=8; 16 samples per run)
//  1 Reset: aresetn=0 mid-RECV after 2 samples -> all outputs 0 immediately; no mem_we, then INIT_ST.
//  2 Full run: START=1, tdata=0x00..0x0F, tvalid=1 -> 4 mem_we pulses, addr 0..3.
//    mem_di@0=0x03020100 ... @3=0x0F0E0D0C; then DONE_REG=1.
//  3 Backpressure: tvalid toggled randomly -> identical memory image.
//    tready=0 exactly 1 cycle after every 4th accept.
//  4 Handshake: START held until DONE, then START=0 -> INIT_ST.
//    Extra samples while in END_ST are never accepted; second run rewrites addr 0..3.
//  5 START drop: START=0 after 5 samples -> run completes all 16 samples, DONE_REG=1 one cycle, then INIT_ST.
//  6 [TLAST_CHECK_EN] tlast on sample 5 -> addr1 written 0x00000504, ERR_REG=1, END_ST.
//    Next run start clears ERR_REG.

Source files
------------

// File: rtl/data_writer_pkg.sv
// Shared types for the AXIS-to-memory deserializer (data_writer).
package data_writer_pkg;

    typedef enum logic [1:0] {
        INIT_ST  = 2'd0,
        RECV_ST  = 2'd1,
        WRITE_ST = 2'd2,
        END_ST   = 2'd3
    } state_t;

    // Depth of the START_REG resynchronizer.
    localparam int unsigned START_SYNC_STAGES = 2;

endpackage

// File: rtl/data_writer_sync.sv
// synchronizer_n: N-stage flop chain bringing an asynchronous level into the aclk domain.
module synchronizer_n #(
    parameter int unsigned STAGES = 2
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/data_writer.sv
// data_writer: packs NM consecutive B-bit AXIS samples into one NM*B-bit word and
// writes the full 2**N-deep map once per START_REG run.
// Optional feature macro: DATA_WRITER_TLAST_CHECK_EN (frame-length check on s_axis_tlast).
module data_writer
    import data_writer_pkg::*;
#(
    parameter int unsigned NM = 8,
    parameter int unsigned N  = 8,
    parameter int unsigned B  = 8
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic [B-1:0]    s_axis_tdata,
    input  logic            s_axis_tlast,
    output logic            mem_we,
    output logic [N-1:0]    mem_addr,
    output logic [NM*B-1:0] mem_di,
    input  logic            START_REG,
    output logic            DONE_REG,
    output logic            ERR_REG
);

    localparam int unsigned    NMW      = $clog2(NM);
    localparam logic [N-1:0]   ADDR_MAX = '1;
    localparam logic [NMW-1:0] LANE_MAX = NMW'(NM - 1);

    state_t            state;
    logic [N-1:0]      cnt_addr;
    logic [NMW-1:0]    cnt_nm;
    logic [NM*B-1:0]   data_reg;
    logic [NM*B-1:0]   data_next;
    logic              START_REG_resync;
    logic              accept;
    logic              word_done;
    logic              last_word;

    synchronizer_n #(
        .STAGES(START_SYNC_STAGES)
    ) u_start_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .d       (START_REG),
        .q       (START_REG_resync)
    );

    assign accept = s_axis_tvalid && s_axis_tready;

    // Data register with the incoming sample merged into the current lane.
    always_comb begin
        data_next = data_reg;
        data_next[int'(cnt_nm)*B +: B] = s_axis_tdata;
    end

`ifdef DATA_WRITER_TLAST_CHECK_EN
    logic is_final;
    logic tlast_early;
    logic tlast_missing;
    logic abort;

    // Frame-length check: tlast must coincide exactly with the last sample of the map.
    always_comb begin
        is_final      = (cnt_addr == ADDR_MAX) && (cnt_nm == LANE_MAX);
        tlast_early   = s_axis_tlast && !is_final;
        tlast_missing = is_final && !s_axis_tlast;
        word_done     = (cnt_nm == LANE_MAX) || tlast_early;
        last_word     = (cnt_addr == ADDR_MAX) || abort;
    end
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign ERR_REG      = 1'b0;

    // Word and run completion from the counters alone.
    always_comb begin
        word_done = (cnt_nm == LANE_MAX);
        last_word = (cnt_addr == ADDR_MAX);
    end
`endif

    // Run control FSM with registered handshake, memory and status outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= INIT_ST;
            cnt_addr      <= '0;
            cnt_nm        <= '0;
            data_reg      <= '0;
            s_axis_tready <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_di        <= '0;
            DONE_REG      <= 1'b0;
`ifdef DATA_WRITER_TLAST_CHECK_EN
            ERR_REG       <= 1'b0;
            abort         <= 1'b0;
`endif
        end else begin
            case (state)
                INIT_ST: begin
                    if (START_REG_resync) begin
                        state         <= RECV_ST;
                        cnt_addr      <= '0;
                        cnt_nm        <= '0;
                        data_reg      <= '0;
                        s_axis_tready <= 1'b1;
`ifdef DATA_WRITER_TLAST_CHECK_EN
                        ERR_REG       <= 1'b0;
                        abort         <= 1'b0;
`endif
                    end
                end

                RECV_ST: begin
                    if (accept) begin
                        data_reg <= data_next;
                        cnt_nm   <= cnt_nm + NMW'(1);
`ifdef DATA_WRITER_TLAST_CHECK_EN
                        if (tlast_early) begin
                            ERR_REG <= 1'b1;
                            abort   <= 1'b1;
                        end
                        if (tlast_missing) begin
                            ERR_REG <= 1'b1;
                        end
`endif
                        if (word_done) begin
                            state         <= WRITE_ST;
                            s_axis_tready <= 1'b0;
                            mem_we        <= 1'b1;
                            mem_addr      <= cnt_addr;
                            mem_di        <= data_next;
                        end
                    end
                end

                WRITE_ST: begin
                    mem_we   <= 1'b0;
                    cnt_addr <= cnt_addr + N'(1);
                    cnt_nm   <= '0;
                    data_reg <= '0;
                    if (last_word) begin
                        state    <= END_ST;
                        DONE_REG <= 1'b1;
                    end else begin
                        state         <= RECV_ST;
                        s_axis_tready <= 1'b1;
                    end
                end

                END_ST: begin
                    if (!START_REG_resync) begin
                        state    <= INIT_ST;
                        DONE_REG <= 1'b0;
                    end
                end

                default: begin
                    state <= INIT_ST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_writer.sv
// Self-checking bench for data_writer with NM=4, N=2, B=8 (16 samples per run).
module tb_data_writer;

    localparam int NM = 4;
    localparam int N  = 2;
    localparam int B  = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic [B-1:0]  s_axis_tdata = '0;
    logic          START_REG = 1'b0;
    logic          s_axis_tready;
    logic          mem_we;
    logic [N-1:0]  mem_addr;
    logic [NM*B-1:0] mem_di;
    logic          DONE_REG;
    logic          ERR_REG;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [N+NM*B-1:0] exp_q[$];
    logic [N+NM*B-1:0] obs_q[$];

    always #5 aclk = ~aclk;

    data_writer #(.NM(NM), .N(N), .B(B)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_di        (mem_di),
        .START_REG     (START_REG),
        .DONE_REG      (DONE_REG),
        .ERR_REG       (ERR_REG)
    );

    // Capture every memory write as it is issued.
    always @(negedge aclk) begin
        if (aresetn && mem_we) obs_q.push_back({mem_addr, mem_di});
    end

    // Expected image of a full run whose samples are base, base+1, ...
    task automatic push_expect(input logic [7:0] base);
        for (int a = 0; a < 4; a++) begin
            logic [31:0] w;
            w = '0;
            for (int k = 0; k < 4; k++) w[k*8 +: 8] = base + 8'(a*4 + k);
            exp_q.push_back({2'(a), w});
        end
    endtask

    // Drive n samples base+i; also checks the one-cycle tready bubble after every 4th accept.
    task automatic drive_samples(input int n, input logic [7:0] base, input bit rnd,
                                 input int drop_at, input int tlast_at);
        int acc = 0;
        int guard = 0;
        bit bubble = 0;
        while (acc < n && guard < 2000) begin
            @(negedge aclk);
            if (bubble) begin
                total_cnt++;
                if (s_axis_tready !== 1'b0)
                    $display("FAIL bubble: tready=%b after accept %0d, required 0", s_axis_tready, acc);
                else pass_cnt++;
                bubble = 0;
            end
            s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tdata  = base + 8'(acc);
            s_axis_tlast  = (acc == tlast_at);
            if (s_axis_tvalid && s_axis_tready) begin
                acc++;
                if (acc % 4 == 0) bubble = 1;
                if (acc == drop_at) START_REG = 1'b0;
            end
            guard++;
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        total_cnt++;
        if (acc != n) $display("FAIL drive_timeout: accepted %0d, required %0d", acc, n);
        else pass_cnt++;
        if (bubble) begin
            total_cnt++;
            if (s_axis_tready !== 1'b0)
                $display("FAIL bubble_last: tready=%b, required 0", s_axis_tready);
            else pass_cnt++;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && DONE_REG !== 1'b1; i++) @(negedge aclk);
        total_cnt++;
        if (DONE_REG !== 1'b1) $display("FAIL done_timeout: DONE_REG=%b, required 1", DONE_REG);
        else pass_cnt++;
    endtask

    task automatic end_run();
        START_REG = 1'b0;
        for (int i = 0; i < 20 && DONE_REG !== 1'b0; i++) @(negedge aclk);
        total_cnt++;
        if ({DONE_REG, s_axis_tready} !== 2'b00)
            $display("FAIL back_to_init: DONE/tready=%b%b, required 00", DONE_REG, s_axis_tready);
        else pass_cnt++;
        repeat (3) @(negedge aclk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        total_cnt++;
        if ({s_axis_tready, mem_we, mem_addr, mem_di, DONE_REG, ERR_REG} !== '0)
            $display("FAIL reset_state: tready=%b we=%b addr=%h di=%h done=%b err=%b, required all 0",
                     s_axis_tready, mem_we, mem_addr, mem_di, DONE_REG, ERR_REG);
        else pass_cnt++;
        aresetn = 1'b1;
        START_REG = 1'b1;
        drive_samples(2, 8'hA0, 0, -1, -1);
        total_cnt++;
        if (s_axis_tready !== 1'b1) $display("FAIL mid_recv_ready: tready=%b, required 1", s_axis_tready);
        else pass_cnt++;
        @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        total_cnt++;
        if ({s_axis_tready, mem_we, mem_addr, mem_di, DONE_REG, ERR_REG} !== '0)
            $display("FAIL async_reset: tready=%b we=%b addr=%h di=%h done=%b, required all 0",
                     s_axis_tready, mem_we, mem_addr, mem_di, DONE_REG);
        else pass_cnt++;
        repeat (3) @(negedge aclk);
        START_REG = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (6) @(negedge aclk);
        total_cnt++;
        if (obs_q.size() != 0 || s_axis_tready !== 1'b0 || DONE_REG !== 1'b0)
            $display("FAIL reset_discard: writes=%0d tready=%b done=%b, required 0 0 0",
                     obs_q.size(), s_axis_tready, DONE_REG);
        else pass_cnt++;
        obs_q.delete();
    endtask

    task automatic test_full_run(input bit rnd);
        START_REG = 1'b1;
        push_expect(8'h00);
        drive_samples(16, 8'h00, rnd, -1, 15);
        wait_done();
        total_cnt++;
        if (obs_q.size() != exp_q.size() || ERR_REG !== 1'b0)
            $display("FAIL run_writes: writes=%0d err=%b, required %0d 0", obs_q.size(), ERR_REG, exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [N+NM*B-1:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL run_word: got addr/data %h, required %h", o, e);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
        end_run();
    endtask

    task automatic test_handshake();
        int bad;
        START_REG = 1'b1;
        push_expect(8'h20);
        drive_samples(16, 8'h20, 0, -1, 15);
        wait_done();
        bad = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'hEE;
        repeat (5) begin
            @(negedge aclk);
            if (s_axis_tready !== 1'b0 || DONE_REG !== 1'b1) bad++;
        end
        s_axis_tvalid = 1'b0;
        total_cnt++;
        if (bad != 0) $display("FAIL end_hold: %0d cycles with tready!=0 or done!=1, required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != 4) $display("FAIL end_writes: writes=%0d, required 4", obs_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [N+NM*B-1:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL hs_word1: got %h, required %h", o, e);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
        end_run();
        START_REG = 1'b1;
        push_expect(8'h40);
        drive_samples(16, 8'h40, 0, -1, 15);
        wait_done();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [N+NM*B-1:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL hs_word2: got %h, required %h", o, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (exp_q.size() != 0 || obs_q.size() != 0)
            $display("FAIL hs_count2: left exp=%0d obs=%0d, required 0 0", exp_q.size(), obs_q.size());
        else pass_cnt++;
        exp_q.delete(); obs_q.delete();
        end_run();
    endtask

    task automatic test_start_drop();
        int hi;
        START_REG = 1'b1;
        push_expect(8'h80);
        drive_samples(16, 8'h80, 0, 5, 15);
        wait_done();
        hi = 0;
        while (DONE_REG === 1'b1 && hi < 10) begin
            hi++;
            @(negedge aclk);
        end
        total_cnt++;
        if (hi != 1) $display("FAIL done_width: DONE_REG high %0d cycles, required 1", hi);
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [N+NM*B-1:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL drop_word: got %h, required %h", o, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (exp_q.size() != 0 || obs_q.size() != 0 || s_axis_tready !== 1'b0)
            $display("FAIL drop_end: exp=%0d obs=%0d tready=%b, required 0 0 0",
                     exp_q.size(), obs_q.size(), s_axis_tready);
        else pass_cnt++;
        exp_q.delete(); obs_q.delete();
        repeat (3) @(negedge aclk);
    endtask

`ifdef DATA_WRITER_TLAST_CHECK_EN
    task automatic test_tlast();
        START_REG = 1'b1;
        exp_q.push_back({2'd0, 32'h03020100});
        exp_q.push_back({2'd1, 32'h00000504});
        drive_samples(6, 8'h00, 0, -1, 5);
        wait_done();
        total_cnt++;
        if (ERR_REG !== 1'b1) $display("FAIL tlast_err: ERR_REG=%b, required 1", ERR_REG);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != 2) $display("FAIL tlast_writes: writes=%0d, required 2", obs_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [N+NM*B-1:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL tlast_word: got %h, required %h", o, e);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
        end_run();
        START_REG = 1'b1;
        for (int i = 0; i < 20 && s_axis_tready !== 1'b1; i++) @(negedge aclk);
        total_cnt++;
        if (ERR_REG !== 1'b0 || s_axis_tready !== 1'b1)
            $display("FAIL err_clear: ERR_REG=%b tready=%b, required 0 1", ERR_REG, s_axis_tready);
        else pass_cnt++;
        drive_samples(16, 8'h00, 0, -1, 15);
        wait_done();
        exp_q.delete(); obs_q.delete();
        end_run();
    endtask
`endif

    initial begin
        test_reset();
        test_full_run(1'b0);
        test_full_run(1'b1);
        test_handshake();
        test_start_drop();
`ifdef DATA_WRITER_TLAST_CHECK_EN
        test_tlast();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
